// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C bus master used as stimulus source and bring-up partner for the
// on-chip I2C slave. A start pulse latches addr/rw/wdata. The master then runs START, 7 address
// bits LSB-first, R/W, ACK, 8 data bits LSB-first, ACK/NACK and STOP.
// SDA is split into two wires: sda_out goes to the slave and sda_in comes back from it.
//
// Ports:
//   clock, reset   system clock; asynchronous active-high reset
//   start          one-cycle request, honoured only while idle
//   addr, rw       7-bit slave address; 0=write, 1=read
//   wdata          byte to write
//   sda_in         SDA from slave (low = ACK)
//   scl, sda_out   bus clock and SDA towards the slave
//   busy, done     transaction in progress; one-cycle end pulse
//   ack_err        sticky NACK flag for the last transaction
//   rdata          byte received on a read
module i2c_master_ctrl #(
  parameter int unsigned LOW_CYC    = 5,
  parameter int unsigned SDA_DLY    = 3,
  parameter int unsigned HIGH_CYC   = 5,
  parameter int unsigned START_HOLD = 2,
  parameter int unsigned STOP_HOLD  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  localparam int unsigned SlotCyc = LOW_CYC + HIGH_CYC;
  // The phase counter also times the START hold, so size it for whichever is longer.
  localparam int unsigned PhCnt   = (SlotCyc > START_HOLD + 1) ? SlotCyc : START_HOLD + 1;
  localparam int unsigned PhW     = (PhCnt > 1) ? $clog2(PhCnt) : 1;

  localparam logic [PhW-1:0] PhLast     = PhW'(SlotCyc - 1);
  localparam logic [PhW-1:0] PhLow      = PhW'(LOW_CYC);
  localparam logic [PhW-1:0] PhSda      = PhW'(SDA_DLY);
  localparam logic [PhW-1:0] PhStopRise = PhW'(LOW_CYC + STOP_HOLD);
  localparam logic [PhW-1:0] PhStartEnd = PhW'(START_HOLD);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StRw,
    StAck1,
    StData,
    StAck2,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             sda_q, sda_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic [7:0]       rdata_q, rdata_d;

  logic             slot_end;
  logic             in_slot;
  logic             slot_bit;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    bit_d     = bit_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;
    scl       = 1'b1;
    sda_out   = 1'b1;
    slot_bit  = 1'b1;
    slot_end  = (phase_q == PhLast);
    in_slot   = 1'b0;

    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        bit_d   = '0;
        if (start) begin
          addr_d    = addr;
          rw_d      = rw;
          wdata_d   = wdata;
          ack_err_d = 1'b0;
          state_d   = StStart;
        end
      end

      StStart: begin
        // One setup cycle with SDA high, then SDA low while SCL stays high.
        sda_out = (phase_q == '0);
        if (phase_q == PhStartEnd) begin
          phase_d = '0;
          bit_d   = '0;
          state_d = StAddr;
        end
      end

      StAddr: begin
        in_slot  = 1'b1;
        slot_bit = addr_q[bit_q];
        if (slot_end) begin
          phase_d = '0;
          if (bit_q == 3'd6) begin
            bit_d   = '0;
            state_d = StRw;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      StRw: begin
        in_slot  = 1'b1;
        slot_bit = rw_q;
        if (slot_end) begin
          phase_d = '0;
          state_d = StAck1;
        end
      end

      StAck1: begin
        in_slot = 1'b1;
        if (slot_end) begin
          phase_d = '0;
          bit_d   = '0;
          if (sda_in) begin
            ack_err_d = 1'b1;
            state_d   = StStop;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
        in_slot  = 1'b1;
        // On a read the master releases SDA so the slave can drive it.
        slot_bit = rw_q ? 1'b1 : wdata_q[bit_q];
        if (slot_end) begin
          phase_d = '0;
          if (rw_q) begin
            rdata_d[bit_q] = sda_in;
          end
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = StAck2;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      StAck2: begin
        // Write: slave ACK slot. Read: master NACK, slave response ignored.
        in_slot = 1'b1;
        if (slot_end) begin
          phase_d = '0;
          if (!rw_q && sda_in) begin
            ack_err_d = 1'b1;
          end
          state_d = StStop;
        end
      end

      StStop: begin
        in_slot  = 1'b1;
        // Pull SDA low during SCL low, release it STOP_HOLD cycles into SCL high.
        slot_bit = (phase_q >= PhStopRise);
        if (slot_end) begin
          phase_d = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        phase_d = '0;
        bit_d   = '0;
        state_d = StIdle;
      end
    endcase

    if (in_slot) begin
      scl     = (phase_q >= PhLow);
      // Before SDA_DLY the previous slot's level is still on the wire.
      sda_out = (phase_q >= PhSda) ? slot_bit : sda_q;
    end

    sda_d = sda_out;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      bit_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      sda_q     <= 1'b1;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      sda_q     <= sda_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a transaction-level model expands each request into the expected
// per-cycle scl/sda_out/busy/done waveform and the slave's sda_in responses; one negedge
// process compares the DUT against that waveform every cycle of the transaction.
module tb_i2c_master_ctrl;

  localparam int LOW   = 5;
  localparam int DLY   = 3;
  localparam int HIGH  = 5;
  localparam int SHOLD = 2;
  localparam int PHOLD = 2;
  localparam int SLOT  = LOW + HIGH;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       sda_in;
  logic       scl;
  logic       sda_out;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;

  always #5 clock = ~clock;

  i2c_master_ctrl #(
    .LOW_CYC   (LOW),
    .SDA_DLY   (DLY),
    .HIGH_CYC  (HIGH),
    .START_HOLD(SHOLD),
    .STOP_HOLD (PHOLD)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .addr   (addr),
    .rw     (rw),
    .wdata  (wdata),
    .sda_in (sda_in),
    .scl    (scl),
    .sda_out(sda_out),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err),
    .rdata  (rdata)
  );

  typedef struct packed {
    logic scl;
    logic sda;
    logic busy;
    logic done;
  } exp_t;

  exp_t       exp_q[$];
  logic       drv_q[$];
  logic       rise_q[$];
  exp_t       e_cur;
  logic       chk_on = 1'b0;
  int         total = 0;
  int         bad = 0;
  logic       m_sda;
  logic [7:0] m_rdata;
  logic       m_err;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic push(input logic s, input logic d, input logic b, input logic dn,
                      input logic r);
    exp_t e;
    e.scl  = s;
    e.sda  = d;
    e.busy = b;
    e.done = dn;
    exp_q.push_back(e);
    drv_q.push_back(r);
  endtask

  // One bit slot carrying b, with the slave holding r on sda_in throughout.
  task automatic push_slot(input logic b, input logic r);
    for (int p = 0; p < SLOT; p++) begin
      push(p >= LOW, (p < DLY) ? m_sda : b, 1'b1, 1'b0, r);
      if (p == LOW) rise_q.push_back(b);
    end
    m_sda = b;
  endtask

  task automatic build(input logic [6:0] a, input logic r, input logic [7:0] wd,
                       input logic ack1, input logic ack2, input logic [7:0] rb);
    exp_q.delete();
    drv_q.delete();
    rise_q.delete();
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < SHOLD; i++) push(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    m_sda = 1'b0;
    for (int i = 0; i < 7; i++) push_slot(a[i], 1'b1);
    push_slot(r, 1'b1);
    push_slot(1'b1, ack1);
    m_err = ack1;
    if (!ack1) begin
      for (int i = 0; i < 8; i++) push_slot(r ? 1'b1 : wd[i], r ? rb[i] : 1'b1);
      push_slot(1'b1, ack2);
      if (r) m_rdata = rb;
      else if (ack2) m_err = 1'b1;
    end
    for (int p = 0; p < SLOT; p++) begin
      push(p >= LOW, (p < DLY) ? m_sda : (p >= LOW + PHOLD), 1'b1, 1'b0, 1'b1);
    end
    push(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  function automatic int model_busy();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].busy) n++;
    return n;
  endfunction

  always @(negedge clock) begin
    if (chk_on) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wave: DUT still running past model end, busy=%b", busy);
      end else begin
        e_cur = exp_q.pop_front();
        if ({scl, sda_out, busy, done} !== e_cur) begin
          bad++;
          $display("FAIL wave: scl/sda/busy/done got %b want %b (cycles left %0d)",
                   {scl, sda_out, busy, done}, e_cur, exp_q.size());
        end
      end
    end
  end

  // inj: cycle at which a second start with wdata=FF is pulsed; rst_at: cycle to assert reset.
  task automatic run_txn(input string nm, input logic [6:0] a, input logic r,
                         input logic [7:0] wd, input logic ack1, input logic ack2,
                         input logic [7:0] rb, input int inj, input int rst_at);
    int n;
    build(a, r, wd, ack1, ack2, rb);
    n = drv_q.size();
    @(posedge clock);
    #1;
    addr   = a;
    rw     = r;
    wdata  = wd;
    sda_in = 1'b1;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    chk_on = 1'b1;
    for (int j = 0; j < n; j++) begin
      sda_in = drv_q[j];
      if (j == inj) begin
        start = 1'b1;
        wdata = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (j == rst_at) begin
        chk_on = 1'b0;
        reset  = 1'b1;
        #1;
        check({nm, " reset outputs"}, {14'd0, scl, sda_out, busy, done}, 18'b1100);
        check({nm, " reset rdata/err"}, {9'd0, rdata, ack_err}, 18'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_rdata = 8'h00;
        m_err   = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    chk_on = 1'b0;
    start  = 1'b0;
    check({nm, " leftover"}, 18'(exp_q.size()), 18'd0);
    check({nm, " ack_err"}, {17'd0, ack_err}, {17'd0, m_err});
    check({nm, " rdata"}, {10'd0, rdata}, {10'd0, m_rdata});
  endtask

  logic [17:0] seq;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    addr   = '0;
    rw     = 1'b0;
    wdata  = '0;
    sda_in = 1'b1;
    m_rdata = 8'h00;
    m_err   = 1'b0;
    #12;
    check("reset state", {9'd0, scl, sda_out, busy, done, ack_err, rdata[3:0]}, 18'b110000000);
    check("reset rdata", {10'd0, rdata}, 18'd0);
    #10;
    reset = 1'b0;

    // Pin the model against hand-derived values.
    build(7'h49, 1'b0, 8'hA7, 1'b0, 1'b0, 8'h00);
    seq = '0;
    foreach (rise_q[i]) seq = {seq[16:0], rise_q[i]};
    check("model sda at scl rise", seq, 18'b100100101111001011);
    check("model busy full", 18'(model_busy()), 18'd193);
    build(7'h49, 1'b0, 8'hA7, 1'b1, 1'b0, 8'h00);
    check("model busy nack", 18'(model_busy()), 18'd103);
    m_err = 1'b0;

    run_txn("write ack", 7'h49, 1'b0, 8'hA7, 1'b0, 1'b0, 8'h00, -1, -1);
    check("write ack_err literal", {17'd0, ack_err}, 18'd0);

    run_txn("addr nack", 7'h49, 1'b0, 8'hA7, 1'b1, 1'b0, 8'h00, -1, -1);
    repeat (3) @(posedge clock);
    #1;
    check("ack_err sticky", {16'd0, ack_err, done}, 18'b10);

    run_txn("read", 7'h22, 1'b1, 8'h00, 1'b0, 1'b1, 8'h5C, -1, -1);
    check("read rdata literal", {10'd0, rdata}, 18'h5C);
    check("read ack_err literal", {17'd0, ack_err}, 18'd0);

    run_txn("data nack", 7'h49, 1'b0, 8'hA7, 1'b0, 1'b1, 8'h00, -1, -1);
    check("data nack literal", {17'd0, ack_err}, 18'd1);

    run_txn("start while busy", 7'h49, 1'b0, 8'hA7, 1'b0, 1'b0, 8'h00, 120, -1);

    run_txn("mid reset", 7'h49, 1'b0, 8'hA7, 1'b0, 1'b0, 8'h00, -1, 110);
    repeat (2) @(posedge clock);
    run_txn("after reset", 7'h33, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
